// File: rtl/l1_cache_pkg.sv
// Shared types and helpers for the write-back L1 data cache.
// Address-split widths and the store byte-merge live here.
package l1_cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EVICT_CMD,
      EVICT_DATA,
      FILL_CMD,
      FILL_DATA,
      RESPOND
   } state_e;

   function automatic int off_w(input int line_words);
      return $clog2(line_words) + 2;
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int sets,
                                input int line_words);
      return addr_w - off_w(line_words) - idx_w(sets);
   endfunction

   function automatic logic [31:0] merge_wstrb(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/l1_cache_way_sel.sv
// Tag compare across the ways of one set.
// Hit requires exactly one matching valid way.
module l1_cache_way_sel #(
   parameter  int WAYS  = 2,
   parameter  int TAG_W = 21,
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic [WAYS-1:0]            valid_i,
   input  logic [WAYS-1:0][TAG_W-1:0] tags_i,
   input  logic [TAG_W-1:0]           tag_i,
   output logic                       hit_o,
   output logic [WAY_W-1:0]           hit_way_o,
   output logic [WAY_W-1:0]           first_invalid_o,
   output logic                       has_invalid_o
);

   logic [WAYS-1:0] match;

   // Descending scan so the lowest-numbered way wins.
   always_comb begin
      match           = '0;
      hit_way_o       = '0;
      first_invalid_o = '0;
      has_invalid_o   = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         match[w] = valid_i[w] && (tags_i[w] == tag_i);
         if (match[w]) hit_way_o = WAY_W'(w);
         if (!valid_i[w]) begin
            first_invalid_o = WAY_W'(w);
            has_invalid_o   = 1'b1;
         end
      end
      hit_o = $onehot(match);
   end

endmodule

// File: rtl/l1_cache_wb.sv
// N-way write-back / write-allocate L1 data cache with burst
// refill and eviction over a line-granular memory port.
module l1_cache_wb import l1_cache_pkg::*; #(
   parameter int SETS       = 64,
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_hit,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_wvalid,
   input  logic              mem_wready,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   localparam int OFF_W  = off_w(LINE_WORDS);
   localparam int IDX_W  = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [WORD_W-1:0] LAST = WORD_W'(LINE_WORDS - 1);

   logic [31:0]      data_q  [SETS][WAYS][LINE_WORDS];
   logic [TAG_W-1:0] tag_q   [SETS][WAYS];
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  dirty_q [SETS];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [WAY_W-1:0]  victim_q, victim_d;
   logic [WORD_W-1:0] beat_q, beat_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_hit_q, resp_hit_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;

   logic [IDX_W-1:0]  req_idx, q_idx;
   logic [TAG_W-1:0]  req_tag, q_tag;
   logic [WORD_W-1:0] req_word, q_word;

   assign req_idx  = req_addr[OFF_W +: IDX_W];
   assign req_tag  = req_addr[OFF_W+IDX_W +: TAG_W];
   assign req_word = req_addr[2 +: WORD_W];
   assign q_idx    = addr_q[OFF_W +: IDX_W];
   assign q_tag    = addr_q[OFF_W+IDX_W +: TAG_W];
   assign q_word   = addr_q[2 +: WORD_W];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[1:0], addr_q[1:0]};

   logic [WAYS-1:0][TAG_W-1:0] set_tags;
   logic                       hit;
   logic [WAY_W-1:0]           hit_way, first_inv;
   logic                       has_inv;

   always_comb begin
      for (int w = 0; w < WAYS; w++) set_tags[w] = tag_q[req_idx][w];
   end

   l1_cache_way_sel #(
      .WAYS  (WAYS),
      .TAG_W (TAG_W)
   ) u_way_sel (
      .valid_i         (valid_q[req_idx]),
      .tags_i          (set_tags),
      .tag_i           (req_tag),
      .hit_o           (hit),
      .hit_way_o       (hit_way),
      .first_invalid_o (first_inv),
      .has_invalid_o   (has_inv)
   );

   logic [WAY_W-1:0] vptr_cur;
   logic             vptr_adv;

   if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] vptr_q [SETS];
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int s = 0; s < SETS; s++) vptr_q[s] <= '0;
         end else if (vptr_adv) begin
            vptr_q[req_idx] <= vptr_q[req_idx] + WAY_W'(1);
         end
      end
      assign vptr_cur = vptr_q[req_idx];
   end else begin : g_dm
      logic unused_vptr_adv;
      assign unused_vptr_adv = vptr_adv;
      assign vptr_cur = '0;
   end

   logic              arr_we;
   logic [IDX_W-1:0]  arr_idx;
   logic [WAY_W-1:0]  arr_way;
   logic [WORD_W-1:0] arr_word;
   logic [31:0]       arr_wdata;
   logic              hit_store, fill_done;

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_hit   = resp_hit_q;
   assign resp_rdata = resp_rdata_q;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      we_d          = we_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      victim_d      = victim_q;
      beat_d        = beat_q;
      resp_valid_d  = 1'b0;
      resp_hit_d    = 1'b0;
      resp_rdata_d  = '0;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = '0;
      mem_wvalid    = 1'b0;
      mem_wdata     = '0;
      arr_we        = 1'b0;
      arr_idx       = q_idx;
      arr_way       = victim_q;
      arr_word      = beat_q;
      arr_wdata     = mem_rdata;
      hit_store     = 1'b0;
      fill_done     = 1'b0;
      vptr_adv      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               we_d    = req_we;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               beat_d  = '0;
               if (hit) begin
                  resp_valid_d = 1'b1;
                  resp_hit_d   = 1'b1;
                  if (req_we) begin
                     arr_we    = 1'b1;
                     arr_idx   = req_idx;
                     arr_way   = hit_way;
                     arr_word  = req_word;
                     arr_wdata = merge_wstrb(
                        data_q[req_idx][hit_way][req_word],
                        req_wdata, req_wstrb);
                     hit_store = 1'b1;
                  end else begin
                     resp_rdata_d = data_q[req_idx][hit_way][req_word];
                  end
               end else begin
                  victim_d = has_inv ? first_inv : vptr_cur;
                  vptr_adv = !has_inv;
                  state_d  = (valid_q[req_idx][victim_d] &&
                              dirty_q[req_idx][victim_d]) ?
                             EVICT_CMD : FILL_CMD;
               end
            end
         end
         EVICT_CMD: begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = {tag_q[q_idx][victim_q], q_idx, OFF_W'(0)};
            if (mem_req_ready) state_d = EVICT_DATA;
         end
         EVICT_DATA: begin
            mem_wvalid = 1'b1;
            mem_wdata  = data_q[q_idx][victim_q][beat_q];
            if (mem_wready) begin
               beat_d = beat_q + WORD_W'(1);
               if (beat_q == LAST) state_d = FILL_CMD;
            end
         end
         FILL_CMD: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {q_tag, q_idx, OFF_W'(0)};
            if (mem_req_ready) state_d = FILL_DATA;
         end
         FILL_DATA: begin
            if (mem_rvalid) begin
               arr_we = 1'b1;
               // Store-allocate merges the store as its word arrives.
               if (we_q && (beat_q == q_word))
                  arr_wdata = merge_wstrb(mem_rdata, wdata_q, wstrb_q);
               beat_d = beat_q + WORD_W'(1);
               if (beat_q == LAST) begin
                  fill_done    = 1'b1;
                  resp_valid_d = 1'b1;
                  if (!we_q)
                     resp_rdata_d = (q_word == LAST) ? mem_rdata :
                                    data_q[q_idx][victim_q][q_word];
                  state_d = RESPOND;
               end
            end
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         victim_q     <= '0;
         beat_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         victim_q     <= victim_d;
         beat_q       <= beat_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         if (hit_store) dirty_q[req_idx][hit_way] <= 1'b1;
         if (fill_done) begin
            valid_q[q_idx][victim_q] <= 1'b1;
            dirty_q[q_idx][victim_q] <= we_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (arr_we) data_q[arr_idx][arr_way][arr_word] <= arr_wdata;
      if (fill_done) tag_q[q_idx][victim_q] <= q_tag;
   end

endmodule

// File: tb/tb_l1_cache_wb.sv
// Directed bench for l1_cache_wb with a bench-side memory responder.
// Refill word i of line L is ((L>>12)+9)<<4 | i.
module tb_l1_cache_wb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_hit;
   logic [31:0] resp_rdata;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [31:0] mem_req_addr;
   logic        mem_wvalid, mem_wready;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   l1_cache_wb dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_wstrb     (req_wstrb),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_hit      (resp_hit),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_wvalid    (mem_wvalid),
      .mem_wready    (mem_wready),
      .mem_wdata     (mem_wdata),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   logic [31:0] cmd_addr [$];
   logic        cmd_we   [$];
   logic [31:0] wbeats   [$];
   bit          fill_active;
   int          fill_idx;
   logic [31:0] fill_base;
   int          stall_at, stall_left;
   bit          stall_seen;
   logic [31:0] stall_hold;

   function automatic logic [31:0] refill(input logic [31:0] base,
                                          input int i);
      return (((base >> 12) + 32'd9) << 4) | 32'(i);
   endfunction

   // Called at each negedge while a miss is in flight.
   task automatic mem_cycle();
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;
      mem_wready    = 1'b0;
      if (fill_active) begin
         mem_rvalid = 1'b1;
         mem_rdata  = refill(fill_base, fill_idx);
         fill_idx++;
         if (fill_idx == 8) fill_active = 0;
      end
      if (mem_req_valid) begin
         mem_req_ready = 1'b1;
         cmd_addr.push_back(mem_req_addr);
         cmd_we.push_back(mem_req_we);
         if (!mem_req_we) begin
            fill_active = 1;
            fill_idx    = 0;
            fill_base   = mem_req_addr;
         end
      end
      if (mem_wvalid) begin
         if (stall_left > 0 && wbeats.size() == stall_at) begin
            if (!stall_seen) begin
               stall_seen = 1;
               stall_hold = mem_wdata;
            end else begin
               check("wdata_stable_in_stall", mem_wdata, stall_hold);
            end
            stall_left--;
         end else begin
            mem_wready = 1'b1;
            wbeats.push_back(mem_wdata);
         end
      end
   endtask

   task automatic run_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rd, output logic hit,
                          output int lat);
      bit tmo;
      cmd_addr.delete();
      cmd_we.delete();
      wbeats.delete();
      stall_seen = 0;
      rd  = '0;
      hit = 1'b0;
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_wdata = '0;
      req_wstrb = '0;
      lat = 0;
      tmo = 1;
      for (int c = 0; c < 300; c++) begin
         lat++;
         if (resp_valid) begin
            rd  = resp_rdata;
            hit = resp_hit;
            tmo = 0;
            break;
         end
         mem_cycle();
         @(negedge clk);
      end
      check("resp_timeout", 32'(tmo), 32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      logic        exp_hit;
      int          exp_cmds;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
      int          stall;
   } vec_t;

   vec_t vecs [16];

   initial begin
      logic [31:0] rd;
      logic        hit;
      int          lat;
      bit          got;

      vecs[0]  = '{1'b0, 32'h1000, 0, 4'h0, 32'hA0, 1'b0, 1, 0, 32'h1000, 0};
      vecs[1]  = '{1'b0, 32'h1004, 0, 4'h0, 32'hA1, 1'b1, 0, 0, 0, 0};
      vecs[2]  = '{1'b1, 32'h1008, 32'hDEADBEEF, 4'h3, 32'h0, 1'b1, 0, 0, 0, 0};
      vecs[3]  = '{1'b0, 32'h1008, 0, 4'h0, 32'h0000BEEF, 1'b1, 0, 0, 0, 0};
      vecs[4]  = '{1'b0, 32'h2000, 0, 4'h0, 32'hB0, 1'b0, 1, 0, 32'h2000, 0};
      vecs[5]  = '{1'b0, 32'h201C, 0, 4'h0, 32'hB7, 1'b1, 0, 0, 0, 0};
      vecs[6]  = '{1'b0, 32'h3000, 0, 4'h0, 32'hC0, 1'b0, 2, 32'h1000, 32'h3000, 5};
      vecs[7]  = '{1'b0, 32'h2004, 0, 4'h0, 32'hB1, 1'b1, 0, 0, 0, 0};
      vecs[8]  = '{1'b0, 32'h100C, 0, 4'h0, 32'hA3, 1'b0, 1, 0, 32'h1000, 0};
      vecs[9]  = '{1'b1, 32'h4010, 32'h11223344, 4'hF, 32'h0, 1'b0, 1, 0, 32'h4000, 0};
      vecs[10] = '{1'b0, 32'h4010, 0, 4'h0, 32'h11223344, 1'b1, 0, 0, 0, 0};
      vecs[11] = '{1'b0, 32'h4014, 0, 4'h0, 32'hD5, 1'b1, 0, 0, 0, 0};
      vecs[12] = '{1'b0, 32'h0020, 0, 4'h0, 32'h90, 1'b0, 1, 0, 32'h0020, 0};
      vecs[13] = '{1'b0, 32'h2000, 0, 4'h0, 32'hB0, 1'b0, 1, 0, 32'h2000, 0};
      vecs[14] = '{1'b0, 32'h3000, 0, 4'h0, 32'hC0, 1'b0, 2, 32'h4000, 32'h3000, 0};
      vecs[15] = '{1'b0, 32'h3004, 0, 4'h0, 32'hC1, 1'b1, 0, 0, 0, 0};

      reset_n       = 1'b0;
      req_valid     = 1'b0;
      req_we        = 1'b0;
      req_addr      = '0;
      req_wdata     = '0;
      req_wstrb     = '0;
      mem_req_ready = 1'b0;
      mem_wready    = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;
      fill_active   = 0;
      fill_idx      = 0;
      fill_base     = '0;
      stall_at      = 0;
      stall_left    = 0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_hit", 32'(resp_hit), 32'd0);
      check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_mem_wvalid", 32'(mem_wvalid), 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         stall_at   = 3;
         stall_left = vecs[i].stall;
         run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 rd, hit, lat);
         check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
         check($sformatf("v%0d_mem_cmds", i), 32'(cmd_addr.size()),
               32'(vecs[i].exp_cmds));
         if (vecs[i].exp_hit)
            check($sformatf("v%0d_hit_latency", i), 32'(lat), 32'd1);
         if (vecs[i].exp_cmds > 0 && cmd_addr.size() > 0) begin
            check($sformatf("v%0d_fill_addr", i),
                  cmd_addr[cmd_addr.size()-1], vecs[i].exp_last);
            check($sformatf("v%0d_fill_we", i),
                  32'(cmd_we[cmd_we.size()-1]), 32'd0);
         end
         if (vecs[i].exp_cmds == 2) begin
            check($sformatf("v%0d_evict_beats", i), 32'(wbeats.size()), 32'd8);
            if (cmd_addr.size() == 2) begin
               check($sformatf("v%0d_evict_addr", i), cmd_addr[0],
                     vecs[i].exp_first);
               check($sformatf("v%0d_evict_we", i), 32'(cmd_we[0]), 32'd1);
            end
         end
         if (vecs[i].stall > 0) begin
            check("stall_consumed", 32'(stall_left), 32'd0);
            if (wbeats.size() == 8) begin
               check("evict_beat0", wbeats[0], 32'hA0);
               check("evict_beat2", wbeats[2], 32'h0000BEEF);
               check("evict_beat3", wbeats[3], 32'hA3);
               check("evict_beat7", wbeats[7], 32'hA7);
            end
         end
      end

      // Reset in the middle of a refill burst.
      cmd_addr.delete();
      cmd_we.delete();
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h0040;
      @(negedge clk);
      req_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 100; c++) begin
         mem_cycle();
         if (fill_active && fill_idx == 3) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      check("midfill_reached", 32'(got), 32'd1);
      @(negedge clk);
      reset_n     = 1'b0;
      mem_rvalid  = 1'b0;
      mem_req_ready = 1'b0;
      fill_active = 0;
      #1;
      check("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_req(1'b0, 32'h0040, 32'h0, 4'h0, rd, hit, lat);
      check("postrst_rdata", rd, 32'h90);
      check("postrst_hit", 32'(hit), 32'd0);
      check("postrst_cmds", 32'(cmd_addr.size()), 32'd1);
      if (cmd_addr.size() == 1)
         check("postrst_fill_addr", cmd_addr[0], 32'h0040);
      run_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, hit, lat);
      check("postrst_old_line_miss", 32'(hit), 32'd0);
      check("postrst_old_line_rdata", rd, 32'hA0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/l1_cache_wb.md
Name: l1_cache_wb

Overview:
- Parametrised N-way set-associative L1 data cache; successor to the fixed 2-way, write-only-allocate L1.
- Adds multi-word lines, byte-strobe writes and write-back/write-allocate with dirty tracking.
- Adds a burst refill/eviction FSM to a line-granular memory port, with valid/ready handshakes on both sides.
- Sits between one core's load/store unit and the shared L2/memory interconnect.

Parameters:
- SETS, 64, number of sets; power of two, >=2.
- WAYS, 2, associativity; power of two, 1..8.
- LINE_WORDS, 8, 32-bit words per line; power of two, >=2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  cache can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- req_wdata  in  32  store data
- req_wstrb  in  4  store byte enables
- resp_valid  out  1  one-cycle pulse; load data or store completion
- resp_rdata  out  32  load data; 0 for stores
- resp_hit  out  1  1 if the request hit without memory traffic
- mem_req_valid  out  1  line command valid
- mem_req_ready  in  1  memory accepts command
- mem_req_we  out  1  1 = writeback burst, 0 = refill burst
- mem_req_addr  out  ADDR_W  line-aligned address; low log2(LINE_WORDS)+2 bits zero
- mem_wvalid  out  1  writeback beat valid
- mem_wready  in  1  writeback beat accepted
- mem_wdata  out  32  writeback beat data, word 0 first
- mem_rvalid  in  1  refill beat valid; no backpressure
- mem_rdata  in  32  refill beat data, word 0 first

Behaviour:
- Address split: offset = log2(LINE_WORDS)+2 bits, index = log2(SETS) bits, tag = remainder.
- Per way per set: valid, dirty, tag, LINE_WORDS data words. Per set: round-robin victim pointer, log2(WAYS) bits.
- Reset (async, reset_n=0):
  - All valid and dirty bits cleared; victim pointers 0; FSM to IDLE.
  - Outputs 0: resp_valid, resp_rdata, resp_hit, mem_req_valid, mem_wvalid. req_ready=1.
  - Data and tag arrays are not reset.
- FSM states: IDLE, EVICT_CMD, EVICT_DATA, FILL_CMD, FILL_DATA, RESPOND.
- IDLE:
  - req_ready=1. A request is accepted on req_valid&&req_ready, and addr/we/wdata/wstrb are latched.
  - Lookup in the same cycle. Hit = exactly one way with valid && tag match.
  - Load hit: resp_valid=1 next cycle with the word and resp_hit=1. Hit latency 1.
  - Store hit: bytes merged per wstrb, line marked dirty, resp_valid next cycle, resp_hit=1.
  - Hits do not change the victim pointer.
  - Back-to-back hits are accepted every cycle.
- Miss:
  - req_ready drops the cycle after acceptance.
  - Victim = lowest-numbered invalid way; otherwise the set's victim pointer, which then increments modulo WAYS.
  - Victim valid && dirty -> EVICT_CMD; else -> FILL_CMD.
- EVICT_CMD: mem_req_valid=1, mem_req_we=1, address = {victim tag, index, 0}. Hold until mem_req_ready, then -> EVICT_DATA.
- EVICT_DATA:
  - LINE_WORDS beats; beat counter advances only on mem_wvalid&&mem_wready.
  - mem_wvalid and mem_wdata held stable while stalled.
  - After the last beat -> FILL_CMD.
- FILL_CMD: mem_req_we=0, address = {req tag, index, 0}. Hold until mem_req_ready, then -> FILL_DATA.
- FILL_DATA:
  - Each mem_rvalid writes one word into the victim way, in order.
  - After the last beat: valid=1, tag written, dirty=0.
  - For a store, req_wdata is merged into the target word and dirty=1.
  - Then -> RESPOND.
- RESPOND: resp_valid=1, resp_hit=0, load data is the refilled word; -> IDLE.
- Boundaries:
  - mem_rvalid outside FILL_DATA is ignored.
  - mem_req_valid never deasserts before mem_req_ready.
  - A new request is never accepted while not IDLE.
  - WAYS=1 degenerates to direct-mapped with victim pointer width 0 (handled by generate).
  - Reset mid-burst aborts the burst immediately. Memory-side recovery is the interconnect's responsibility.

Decomposition:
- Package l1_cache_pkg holds:
  - state_e enum (IDLE, EVICT_CMD, EVICT_DATA, FILL_CMD, FILL_DATA, RESPOND);
  - localparam functions for offset/index/tag widths;
  - byte-merge function merge_wstrb(old, new, strb).
- One sub-module, l1_cache_way_sel: combinational tag compare over WAYS producing hit, hit_way, first_invalid and has_invalid.

Test Plan:
- Reset, then load 0x0000_1000 -> miss. FILL_CMD addr 0x0000_1000, 8 refill beats 0xA0..0xA7; resp_rdata=0xA0, resp_hit=0.
- Repeat load 0x0000_1004 -> resp_valid 1 cycle after acceptance, resp_rdata=0xA1, resp_hit=1, no mem_req_valid.
- Store 0x0000_1008, wdata 0xDEADBEEF, wstrb 0b0011 over 0xA2 -> load returns 0x0000BEEF, hit.
- Fill both ways of index 0 (0x0000_1000, 0x0000_2000), then load 0x0000_3000:
  - dirty way 0 evicted first: EVICT addr 0x0000_1000, beat 2 = 0x0000BEEF;
  - then refill from 0x0000_3000.
- Hold mem_wready=0 for 5 cycles mid-eviction -> mem_wdata stable, no beat skipped, total beats exactly 8.
- Assert reset_n=0 during FILL_DATA, then reload the same address -> miss, full refill, resp_hit=0.
